alu_arbiter: RTL and testbench

//  Shares one combinational ALU instance among NUM_REQ requesters (e.g. issue stage, address-gen unit).

---
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external combinational ALU among
// NUM_REQ requesters. One operation in flight; the result is registered and
// held under a valid/ready handshake until the consumer takes it.
module alu_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ID_W    = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [3*NUM_REQ-1:0]   req_opcode,
   input  logic [32*NUM_REQ-1:0]  req_op_0,
   input  logic [32*NUM_REQ-1:0]  req_op_1,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic [2:0]             alu_opcode,
   output logic [31:0]            alu_op_0,
   output logic [31:0]            alu_op_1,
   input  logic [31:0]            alu_out,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [ID_W-1:0]        rsp_id,
   output logic [31:0]            rsp_out,
   output logic                   rsp_zero,
   output logic                   rsp_negative
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_EXEC = 2'd1,
      S_RESP = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ID_W-1:0]   r_ptr;
   logic [2:0]        r_opcode;
   logic [31:0]       r_op_0;
   logic [31:0]       r_op_1;
   logic [ID_W-1:0]   r_id;
   logic [31:0]       r_out;
   logic              r_zero;
   logic              r_neg;

   logic              w_any;
   logic [ID_W-1:0]   w_grant;
   logic [ID_W-1:0]   w_ptr_nxt;
   logic [2:0]        w_sel_opcode;
   logic [31:0]       w_sel_op_0;
   logic [31:0]       w_sel_op_1;
   logic              w_accept;
   logic              w_capture;

   // Round-robin search from r_ptr; scanning backwards lets the nearest index win.
   always_comb begin
      w_any     = 1'b0;
      w_grant   = '0;
      w_ptr_nxt = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (req_valid[(int'(r_ptr) + k) % NUM_REQ]) begin
            w_any   = 1'b1;
            w_grant = ID_W'((int'(r_ptr) + k) % NUM_REQ);
         end
      end
      w_ptr_nxt = ID_W'((int'(w_grant) + 1) % NUM_REQ);
   end

   // Select the winning requester's opcode and operands.
   always_comb begin
      w_sel_opcode = '0;
      w_sel_op_0   = '0;
      w_sel_op_1   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (ID_W'(i) == w_grant) begin
            w_sel_opcode = req_opcode[3*i +: 3];
            w_sel_op_0   = req_op_0[32*i +: 32];
            w_sel_op_1   = req_op_1[32*i +: 32];
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // FSM next state and strobes; req_ready is held low while reset is asserted.
   always_comb begin
      w_state_nxt = r_state;
      req_ready   = '0;
      w_accept    = 1'b0;
      w_capture   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_any && rst_n) begin
               req_ready   = NUM_REQ'(1) << w_grant;
               w_accept    = 1'b1;
               w_state_nxt = S_EXEC;
            end
         end
         S_EXEC: begin
            w_capture   = 1'b1;
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (rsp_ready) w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Latch the granted request and advance the round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr    <= '0;
         r_opcode <= '0;
         r_op_0   <= '0;
         r_op_1   <= '0;
         r_id     <= '0;
      end else if (w_accept) begin
         r_ptr    <= w_ptr_nxt;
         r_opcode <= w_sel_opcode;
         r_op_0   <= w_sel_op_0;
         r_op_1   <= w_sel_op_1;
         r_id     <= w_grant;
      end
   end

   // Register the ALU result and derive flags from it (ALU flags are not used).
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out  <= '0;
         r_zero <= 1'b0;
         r_neg  <= 1'b0;
      end else if (w_capture) begin
         r_out  <= alu_out;
         r_zero <= (alu_out == 32'd0);
         r_neg  <= alu_out[31];
      end
   end

   // ALU inputs come only from latched state, never from live request buses.
   assign alu_opcode   = r_opcode;
   assign alu_op_0     = r_op_0;
   assign alu_op_1     = r_op_1;
   assign rsp_valid    = (r_state == S_RESP);
   assign rsp_id       = r_id;
   assign rsp_out      = r_out;
   assign rsp_zero     = r_zero;
   assign rsp_negative = r_neg;

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed vectors for alu_arbiter with 2 and 3 requesters,
// each instance wired to a small combinational ALU.
module tb_alu_arbiter;

   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR  = 3'd3,
                          OP_XOR = 3'd4, OP_SLL = 3'd5, OP_SRL = 3'd6, OP_SRA = 3'd7;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // two-requester instance
   logic [1:0]  v2;
   logic [5:0]  op2;
   logic [63:0] a2, b2;
   logic [1:0]  rdy2;
   logic [2:0]  ao2;
   logic [31:0] a0_2, a1_2, aout2, out2;
   logic        rv2, rr2, z2, n2;
   logic [1:0]  id2;

   // three-requester instance
   logic [2:0]  v3;
   logic [8:0]  op3;
   logic [95:0] a3, b3;
   logic [2:0]  rdy3;
   logic [2:0]  ao3;
   logic [31:0] a0_3, a1_3, aout3, out3;
   logic        rv3, rr3, z3, n3;
   logic [1:0]  id3;

   function automatic logic [31:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         OP_ADD:  return a + b;
         OP_SUB:  return a - b;
         OP_AND:  return a & b;
         OP_OR:   return a | b;
         OP_XOR:  return a ^ b;
         OP_SLL:  return a << b[4:0];
         OP_SRL:  return a >> b[4:0];
         default: return 32'($signed(a) >>> b[4:0]);
      endcase
   endfunction

   assign aout2 = alu_f(ao2, a0_2, a1_2);
   assign aout3 = alu_f(ao3, a0_3, a1_3);

   alu_arbiter #(.NUM_REQ(2), .ID_W(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n), .req_valid(v2), .req_opcode(op2), .req_op_0(a2), .req_op_1(b2),
      .req_ready(rdy2), .alu_opcode(ao2), .alu_op_0(a0_2), .alu_op_1(a1_2), .alu_out(aout2),
      .rsp_valid(rv2), .rsp_ready(rr2), .rsp_id(id2), .rsp_out(out2), .rsp_zero(z2), .rsp_negative(n2)
   );

   alu_arbiter #(.NUM_REQ(3), .ID_W(2)) u_dut3 (
      .clk(clk), .rst_n(rst_n), .req_valid(v3), .req_opcode(op3), .req_op_0(a3), .req_op_1(b3),
      .req_ready(rdy3), .alu_opcode(ao3), .alu_op_0(a0_3), .alu_op_1(a1_3), .alu_out(aout3),
      .rsp_valid(rv3), .rsp_ready(rr3), .rsp_id(id3), .rsp_out(out3), .rsp_zero(z3), .rsp_negative(n3)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic set2(input int i, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      v2[i]          = v;
      op2[3*i +: 3]  = op;
      a2[32*i +: 32] = a;
      b2[32*i +: 32] = b;
   endtask

   task automatic set3(input int i, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      v3[i]          = v;
      op3[3*i +: 3]  = op;
      a3[32*i +: 32] = a;
      b3[32*i +: 32] = b;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      v2 = '0; op2 = '0; a2 = '0; b2 = '0; rr2 = 1'b1;
      v3 = '0; op3 = '0; a3 = '0; b3 = '0; rr3 = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Wait (bounded) for a dut2 response at a negedge and check its fields.
   task automatic serve2(input string tag, input logic [1:0] id, input logic [31:0] res,
                         input logic zero, input logic neg);
      int budget = 8;
      @(negedge clk);
      while (!rv2 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk({tag, "_valid"}, 32'(rv2), 32'd1);
      chk({tag, "_id"},    32'(id2), 32'(id));
      chk({tag, "_out"},   out2, res);
      chk({tag, "_zero"},  32'(z2), 32'(zero));
      chk({tag, "_neg"},   32'(n2), 32'(neg));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen;
      int   cnt;
      int   ids[4];
      int   cyc[4];
      int   budget;

      // reset state
      rst_n = 1'b0;
      v2 = 2'b01; op2 = '0; a2 = '0; b2 = '0; rr2 = 1'b1;
      v3 = '0; op3 = '0; a3 = '0; b3 = '0; rr3 = 1'b1;
      @(negedge clk);
      chk("rst_ready",  32'(rdy2), 32'd0);
      chk("rst_valid",  32'(rv2),  32'd0);
      chk("rst_out",    out2,      32'd0);
      chk("rst_id",     32'(id2),  32'd0);
      chk("rst_flags",  {30'd0, z2, n2}, 32'd0);
      chk("rst_alu",    a0_2 | a1_2 | 32'(ao2), 32'd0);

      // 1: req0 ADD 5,7 alone
      do_reset();
      set2(0, 1'b1, OP_ADD, 32'd5, 32'd7);
      #1 chk("t1_ready", 32'(rdy2), 32'd1);
      @(negedge clk);
      chk("t1_ready_once", 32'(rdy2), 32'd0);
      chk("t1_not_yet",    32'(rv2),  32'd0);
      chk("t1_alu_op0",    a0_2,      32'd5);
      set2(0, 1'b0, OP_ADD, 32'd5, 32'd7);
      @(negedge clk);
      chk("t1_valid", 32'(rv2), 32'd1);
      chk("t1_out",   out2,     32'd12);
      chk("t1_id",    32'(id2), 32'd0);
      chk("t1_flags", {30'd0, z2, n2}, 32'd0);
      @(negedge clk);
      chk("t1_done",  32'(rv2), 32'd0);

      // 2: req0 and req1 together, rotation and wrap
      do_reset();
      set2(0, 1'b1, OP_ADD, 32'd1,  32'd2);
      set2(1, 1'b1, OP_ADD, 32'd10, 32'd20);
      #1 chk("t2_ready0", 32'(rdy2), 32'd1);
      @(negedge clk);
      set2(0, 1'b0, OP_ADD, 32'd1, 32'd2);
      serve2("t2_a", 2'd0, 32'd3, 1'b0, 1'b0);
      @(negedge clk);
      chk("t2_ready1", 32'(rdy2), 32'd2);
      @(negedge clk);
      set2(1, 1'b0, OP_ADD, 32'd10, 32'd20);
      serve2("t2_b", 2'd1, 32'd30, 1'b0, 1'b0);
      @(negedge clk);
      set2(0, 1'b1, OP_ADD, 32'd0, 32'd0);
      set2(1, 1'b1, OP_ADD, 32'd0, 32'd0);
      #1 chk("t2_wrap", 32'(rdy2), 32'd1);
      v2 = 2'b00;

      // 3: SUB gives negative, XOR x,x gives zero
      do_reset();
      set2(1, 1'b1, OP_SUB, 32'd3, 32'd5);
      #1 chk("t3_ready_sub", 32'(rdy2), 32'd2);
      @(negedge clk);
      set2(1, 1'b0, OP_SUB, 32'd3, 32'd5);
      serve2("t3_sub", 2'd1, 32'hFFFF_FFFE, 1'b0, 1'b1);
      @(negedge clk);
      set2(0, 1'b1, OP_XOR, 32'h1234_5678, 32'h1234_5678);
      #1 chk("t3_ready_xor", 32'(rdy2), 32'd1);
      @(negedge clk);
      set2(0, 1'b0, OP_XOR, 32'd0, 32'd0);
      serve2("t3_xor", 2'd0, 32'd0, 1'b1, 1'b0);

      // 4: backpressure in RESP with req0 still valid
      do_reset();
      rr2 = 1'b0;
      set2(0, 1'b1, OP_ADD, 32'd100, 32'd1);
      @(negedge clk);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         chk("t4_hold_valid", 32'(rv2),  32'd1);
         chk("t4_hold_out",   out2,      32'd101);
         chk("t4_no_grant",   32'(rdy2), 32'd0);
         @(negedge clk);
      end
      rr2 = 1'b1;
      @(negedge clk);
      chk("t4_released", 32'(rv2),  32'd0);
      chk("t4_regrant",  32'(rdy2), 32'd1);
      v2 = 2'b00;

      // 5: reset during EXEC discards the operation
      do_reset();
      set2(0, 1'b1, OP_ADD, 32'd1, 32'd1);
      @(negedge clk);
      chk("t5_exec_op0", a0_2, 32'd1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_ready", 32'(rdy2), 32'd0);
      chk("t5_rst_valid", 32'(rv2),  32'd0);
      chk("t5_rst_alu",   a0_2 | a1_2, 32'd0);
      chk("t5_rst_out",   out2,      32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      set2(0, 1'b0, OP_ADD, 32'd0, 32'd0);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         seen = seen | rv2;
      end
      chk("t5_no_rsp", 32'(seen), 32'd0);

      // 6a: SRA by op_1[4:0] on the three-requester instance
      do_reset();
      set3(0, 1'b1, OP_SRA, 32'h8000_0000, 32'd36);
      #1 chk("t6_ready", 32'(rdy3), 32'd1);
      @(negedge clk);
      set3(0, 1'b0, OP_SRA, 32'd0, 32'd0);
      budget = 8;
      @(negedge clk);
      while (!rv3 && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      chk("t6_sra_valid", 32'(rv3), 32'd1);
      chk("t6_sra_out",   out3,     32'hF800_0000);
      chk("t6_sra_neg",   32'(n3),  32'd1);
      chk("t6_sra_zero",  32'(z3),  32'd0);

      // 6b: all three continuously valid -> ids 0,1,2,0 every 3 cycles
      do_reset();
      set3(0, 1'b1, OP_ADD, 32'd0, 32'd100);
      set3(1, 1'b1, OP_ADD, 32'd1, 32'd100);
      set3(2, 1'b1, OP_ADD, 32'd2, 32'd100);
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (rv3 && cnt < 4) begin
            ids[cnt] = int'(id3);
            cyc[cnt] = c;
            cnt++;
         end
      end
      v3 = '0;
      chk("t6_rsp_count", 32'(cnt), 32'd4);
      if (cnt == 4) begin
         chk("t6_id0", 32'(ids[0]), 32'd0);
         chk("t6_id1", 32'(ids[1]), 32'd1);
         chk("t6_id2", 32'(ids[2]), 32'd2);
         chk("t6_id3", 32'(ids[3]), 32'd0);
         for (int k = 1; k < 4; k++)
            chk("t6_spacing", 32'(cyc[k] - cyc[k-1]), 32'd3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
